// File: rtl/dmem_port_arbiter.sv
// N-port req/gnt arbiter in front of the single-port data memory.
// Round-robin or fixed priority with bounded locking, tagged read return.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PORTS   = 2,
  parameter int MEM_LATENCY = 1,
  parameter int ARB_MODE    = 0,
  parameter int MAX_LOCK    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_in,
  input  logic [NUM_PORTS-1:0]            we_in,
  input  logic [NUM_PORTS-1:0]            lock_in,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_in,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_in,
  output logic [NUM_PORTS-1:0]            gnt_out,
  output logic [NUM_PORTS-1:0]            rvalid_out,
  output logic [DATA_WIDTH-1:0]           rdata_out,
  output logic [ADDR_WIDTH-1:0]           mem_addr_out,
  output logic [DATA_WIDTH-1:0]           mem_data_out,
  output logic                            mem_wren_out,
  input  logic [DATA_WIDTH-1:0]           mem_q_in,
  output logic                            busy_out
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);
  localparam int LAST = MEM_LATENCY - 1;

  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        lock_owner;
  logic                 lock_vld;
  logic [3:0]           lock_cnt;
  logic [MEM_LATENCY-1:0]         pipe_vld;
  logic [MEM_LATENCY-1:0][IW-1:0] pipe_port;

  logic [NUM_PORTS-1:0] owner_bit;
  logic [NUM_PORTS-1:0] cand;
  logic                 forced;
  logic                 lock_win;
  logic                 gnt_vld;
  logic [IW-1:0]        gnt_idx;
  int                   sel;

  always_comb begin
    owner_bit = '0;
    owner_bit[lock_owner] = 1'b1;
    forced   = lock_vld && (lock_cnt >= LOCK_MAX);
    lock_win = rst_n && lock_vld && !forced
               && req_in[lock_owner];
    cand = req_in;
    // an expired owner sits out one cycle only if someone else waits
    if (forced && |(req_in & ~owner_bit))
      cand = req_in & ~owner_bit;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sel     = 0;
    if (rst_n) begin
      if (lock_win) begin
        gnt_vld = 1'b1;
        gnt_idx = lock_owner;
      end else begin
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
          if (ARB_MODE == 1)
            sel = k;
          else
            sel = (int'(rr_ptr) + k) % NUM_PORTS;
          if (cand[sel]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(sel);
          end
        end
      end
    end
  end

  always_comb begin
    gnt_out    = '0;
    rvalid_out = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      gnt_out[i]    = gnt_vld && (gnt_idx == IW'(i));
      rvalid_out[i] = pipe_vld[LAST]
                      && (pipe_port[LAST] == IW'(i));
    end
  end

  assign mem_addr_out = gnt_vld
    ? addr_in[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_data_out = gnt_vld
    ? wdata_in[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign mem_wren_out = gnt_vld && we_in[gnt_idx];
  assign rdata_out    = pipe_vld[LAST] ? mem_q_in : '0;
  assign busy_out     = |pipe_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      lock_owner <= '0;
      lock_vld   <= 1'b0;
      lock_cnt   <= '0;
      pipe_vld   <= '0;
      pipe_port  <= '0;
    end else begin
      if (gnt_vld)
        rr_ptr <= (int'(gnt_idx) == NUM_PORTS - 1)
                  ? '0 : gnt_idx + 1'b1;
      if (gnt_vld && lock_in[gnt_idx]) begin
        lock_vld   <= 1'b1;
        lock_owner <= gnt_idx;
        lock_cnt   <= (lock_win ? lock_cnt : 4'd0) + 4'd1;
      end else begin
        lock_vld <= 1'b0;
        lock_cnt <= '0;
      end
      pipe_vld[0]  <= gnt_vld && !we_in[gnt_idx];
      pipe_port[0] <= gnt_idx;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        pipe_vld[s]  <= pipe_vld[s-1];
        pipe_port[s] <= pipe_port[s-1];
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: RR/lock (lat 1), fixed priority (lat 2),
// reset during an in-flight read (lat 3).
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // instance A: round-robin, latency 1
  logic [1:0]  a_req, a_we, a_lock, a_gnt, a_rv;
  logic [15:0] a_addr;
  logic [63:0] a_wd;
  logic [31:0] a_rd, a_md, a_q;
  logic [7:0]  a_ma;
  logic        a_wr, a_busy;
  logic [31:0] mem_a [256];

  dmem_port_arbiter #(.MEM_LATENCY(1), .ARB_MODE(0), .MAX_LOCK(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req_in(a_req), .we_in(a_we),
    .lock_in(a_lock), .addr_in(a_addr), .wdata_in(a_wd),
    .gnt_out(a_gnt), .rvalid_out(a_rv), .rdata_out(a_rd),
    .mem_addr_out(a_ma), .mem_data_out(a_md), .mem_wren_out(a_wr),
    .mem_q_in(a_q), .busy_out(a_busy));

  always @(posedge clk) begin
    a_q <= mem_a[a_ma];
    if (a_wr) mem_a[a_ma] <= a_md;
  end

  // instance B: fixed priority, latency 2
  logic [1:0]  b_req, b_we, b_lock, b_gnt, b_rv;
  logic [15:0] b_addr;
  logic [63:0] b_wd;
  logic [31:0] b_rd, b_md, b_q, b_q1;
  logic [7:0]  b_ma;
  logic        b_wr, b_busy;
  logic [31:0] mem_b [256];

  dmem_port_arbiter #(.MEM_LATENCY(2), .ARB_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req_in(b_req), .we_in(b_we),
    .lock_in(b_lock), .addr_in(b_addr), .wdata_in(b_wd),
    .gnt_out(b_gnt), .rvalid_out(b_rv), .rdata_out(b_rd),
    .mem_addr_out(b_ma), .mem_data_out(b_md), .mem_wren_out(b_wr),
    .mem_q_in(b_q), .busy_out(b_busy));

  always @(posedge clk) begin
    b_q1 <= mem_b[b_ma];
    b_q  <= b_q1;
    if (b_wr) mem_b[b_ma] <= b_md;
  end

  // instance C: round-robin, latency 3
  logic [1:0]  c_req, c_we, c_lock, c_gnt, c_rv;
  logic [15:0] c_addr;
  logic [63:0] c_wd;
  logic [31:0] c_rd, c_md;
  logic [31:0] c_q = 32'hCAFE_0000;
  logic [7:0]  c_ma;
  logic        c_wr, c_busy;

  dmem_port_arbiter #(.MEM_LATENCY(3), .ARB_MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .req_in(c_req), .we_in(c_we),
    .lock_in(c_lock), .addr_in(c_addr), .wdata_in(c_wd),
    .gnt_out(c_gnt), .rvalid_out(c_rv), .rdata_out(c_rd),
    .mem_addr_out(c_ma), .mem_data_out(c_md), .mem_wren_out(c_wr),
    .mem_q_in(c_q), .busy_out(c_busy));

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[8'h10] = 32'h1111_0010;
    mem_a[8'h20] = 32'h2222_0020;
    a_req = 2'b11; a_we = 2'b00; a_lock = 2'b00;
    a_addr = 16'h2010; a_wd = '0;
    b_req = 2'b11; b_we = 2'b00; b_lock = 2'b00;
    b_addr = 16'h3305; b_wd = '0;
    c_req = 2'b11; c_we = 2'b00; c_lock = 2'b00;
    c_addr = 16'h0201; c_wd = '0;

    // reset held with requests pending
    @(negedge clk); #1;
    check("rst_gnt", 32'(a_gnt), 32'h0);
    check("rst_rvalid", 32'(a_rv), 32'h0);
    check("rst_wren", 32'(a_wr), 32'h0);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_maddr", 32'(a_ma), 32'h0);
    check("rst_rdata", a_rd, 32'h0);
    check("rst_gnt_c", 32'(c_gnt), 32'h0);

    // release: RR alternates from port 0
    @(negedge clk);
    rst_n = 1'b1;
    c_req = 2'b00;
    #1;
    check("rr_gnt0", 32'(a_gnt), 32'h1);
    check("rr_maddr0", 32'(a_ma), 32'h10);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      check("rr_gnt", 32'(a_gnt), (k % 2) ? 32'h2 : 32'h1);
      check("rr_rvalid", 32'(a_rv), (k % 2) ? 32'h1 : 32'h2);
      check("rr_rdata", a_rd,
            (k % 2) ? 32'h1111_0010 : 32'h2222_0020);
    end
    @(negedge clk);
    a_req = 2'b00;
    #1;
    check("rr_idle_gnt", 32'(a_gnt), 32'h0);
    check("rr_last_rv", 32'(a_rv), 32'h2);
    check("rr_last_rd", a_rd, 32'h2222_0020);
    check("rr_busy", 32'(a_busy), 32'h1);

    // lock: port 1 holds four grants, then port 0
    @(negedge clk);
    a_req = 2'b10; a_lock = 2'b10;
    #1;
    check("lk_gnt0", 32'(a_gnt), 32'h2);
    check("idle_busy", 32'(a_busy), 32'h0);
    @(negedge clk);
    a_req = 2'b11;
    #1;
    check("lk_gnt1", 32'(a_gnt), 32'h2);
    for (int k = 2; k < 4; k++) begin
      @(negedge clk); #1;
      check("lk_gnt", 32'(a_gnt), 32'h2);
    end
    @(negedge clk); #1;
    check("lk_release", 32'(a_gnt), 32'h1);
    check("lk_rel_addr", 32'(a_ma), 32'h10);
    @(negedge clk); #1;
    check("lk_regrant", 32'(a_gnt), 32'h2);
    @(negedge clk);
    a_req = 2'b00; a_lock = 2'b00;

    // fixed priority: port 0 always wins
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("fp_gnt", 32'(b_gnt), 32'h1);
    end
    // write then read back at latency 2
    @(negedge clk);
    b_req = 2'b01; b_we = 2'b01;
    b_wd = {32'h0, 32'hDEAD_BEEF};
    #1;
    check("wr_wren", 32'(b_wr), 32'h1);
    check("wr_addr", 32'(b_ma), 32'h05);
    check("wr_data", b_md, 32'hDEAD_BEEF);
    @(negedge clk);
    b_we = 2'b00;
    #1;
    check("rd_wren", 32'(b_wr), 32'h0);
    check("rd_gnt", 32'(b_gnt), 32'h1);
    @(negedge clk);
    b_req = 2'b00;
    #1;
    check("rd_rv_early", 32'(b_rv), 32'h0);
    @(negedge clk); #1;
    check("rd_rvalid", 32'(b_rv), 32'h1);
    check("rd_rdata", b_rd, 32'hDEAD_BEEF);

    // reset during an in-flight read
    @(negedge clk);
    c_req = 2'b01;
    #1;
    check("rm_gnt", 32'(c_gnt), 32'h1);
    @(negedge clk);
    c_req = 2'b00;
    #1;
    check("rm_busy", 32'(c_busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rm_rst_busy", 32'(c_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rm_no_rv", 32'(c_rv), 32'h0);
      @(negedge clk);
    end
    #1;
    check("rm_busy_end", 32'(c_busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Parametrised N-port arbiter for the single-port synchronous data memory. It replaces the fixed two-way core/LCD address selector. Each requester (core load/store path, LCD/debug reader, future DMA) issues requests under a req/gnt handshake. The block selects one port per cycle by round-robin or fixed priority, drives the memory, and returns read data tagged to the originating port after the memory latency.

Parameters:
ADDR_WIDTH, 8, data memory address width
DATA_WIDTH, 32, data word width
NUM_PORTS, 2, number of requesters (2..8)
MEM_LATENCY, 1, memory read latency in clocks (1..4)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
MAX_LOCK, 4, maximum consecutive grants a locking port may hold (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
req_in  in  NUM_PORTS  per-port request, held until granted
we_in  in  NUM_PORTS  per-port write enable (1 = write, 0 = read)
lock_in  in  NUM_PORTS  per-port request to keep the grant next cycle
addr_in  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata_in  in  NUM_PORTS*DATA_WIDTH  packed write data
gnt_out  out  NUM_PORTS  one-hot grant, current cycle
rvalid_out  out  NUM_PORTS  one-hot read-data-valid strobe
rdata_out  out  DATA_WIDTH  read data, shared by all ports
mem_addr_out  out  ADDR_WIDTH  to data memory address
mem_data_out  out  DATA_WIDTH  to data memory data
mem_wren_out  out  1  to data memory wren
mem_q_in  in  DATA_WIDTH  from data memory q
busy_out  out  1  read in flight

Behaviour:
- Reset (async, rst_n = 0):
  - rr_ptr = 0, lock_owner cleared, lock_cnt = 0, read pipeline cleared.
  - gnt_out, rvalid_out, mem_wren_out and busy_out are 0.
  - mem_addr_out, mem_data_out and rdata_out are 0.
- Grant is combinational from req_in and the registered state, so a request can be granted in the same cycle it is raised. At most one gnt_out bit is high. With no request, gnt_out = 0 and mem_wren_out = 0.
- Round-robin (ARB_MODE 0): search starts at rr_ptr and wraps modulo NUM_PORTS. On a grant to port g, rr_ptr <= (g+1) mod NUM_PORTS. With no grant, rr_ptr is unchanged.
- Fixed priority (ARB_MODE 1): the lowest-index requester wins. rr_ptr is ignored.
- Lock:
  - If the granted port has lock_in = 1, it becomes lock_owner and lock_cnt increments.
  - While lock_owner requests and lock_cnt < MAX_LOCK, it wins regardless of mode.
  - When lock_cnt reaches MAX_LOCK, or the owner drops req or lock, the lock clears and lock_cnt = 0.
  - A forced release makes normal arbitration apply in that cycle. The owner is excluded for that one cycle only if another port requests.
- Memory drive in a grant cycle:
  - mem_addr_out and mem_data_out come from the granted slice.
  - mem_wren_out = we_in[g].
- Read pipeline:
  - A granted read enters a MEM_LATENCY-deep shift register carrying valid and port index.
  - rvalid_out[g] pulses for exactly one cycle, MEM_LATENCY cycles after the grant edge.
  - rdata_out = mem_q_in in that cycle, passed through with no extra register.
  - Back-to-back reads are fully pipelined: one per cycle.
- Writes produce no rvalid. They complete at the grant clock edge.
- busy_out = OR of the pipeline valid bits.
- A read followed immediately by a write to the same address returns the old data, because memory reads before it writes.
- Requesters must keep addr, we and wdata stable while req is high and not granted. Changing them before the grant is a protocol violation with undefined results.
- Reset mid-read discards in-flight reads: no rvalid is issued after reset release.

Test Plan:
- Reset with req_in = 2'b11 held: gnt_out = 0, rvalid_out = 0 and mem_wren_out = 0 while rst_n = 0. On the first cycle after release, port 0 is granted (rr_ptr = 0).
- RR, NUM_PORTS = 2, both ports requesting reads of addresses 0x10 and 0x20 for 4 cycles: grants alternate 0,1,0,1. rvalid_out[0] appears 1 cycle later with mem_q_in = mem[0x10], then rvalid_out[1] with mem[0x20].
- Fixed mode, ports 0 and 1 both requesting for 3 cycles: port 0 is granted every cycle and gnt_out[1] stays 0.
- Lock, MAX_LOCK = 4: port 1 holds lock_in and req while port 0 also requests. Port 1 is granted 4 consecutive cycles, then port 0 on the 5th.
- Write then read: port 0 writes 0xDEADBEEF to 0x05 (mem_wren_out = 1 for one cycle). A following read of 0x05 returns 0xDEADBEEF with rvalid_out[0] after MEM_LATENCY = 2 cycles.
- Reset asserted 1 cycle after a read grant with MEM_LATENCY = 3: no rvalid_out pulse occurs and busy_out = 0 after release.
